// File: rtl/leaf_uplink_rr_arbiter.sv
// -----------------------------------------------------------------------------
// leaf_uplink_rr_arbiter
//
// Purpose:
//   Merges the parent_tx message streams of NUM_LEAVES leaf decoders into a
//   single stream towards the root-hub up_rx port. Leaves are granted in fair
//   round-robin order. The merged word passes through one registered output
//   stage, and the index of the source leaf travels with it.
//
// Ports:
//   clk        in   single clock, all logic on posedge
//   reset      in   synchronous, active-high
//   in_data    in   leaf i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
//   in_valid   in   per-leaf valid
//   in_ready   out  per-leaf ready (combinational, at most one bit set)
//   out_data   out  registered merged message
//   out_valid  out  registered valid
//   out_ready  in   root-hub backpressure
//   out_src    out  leaf index of out_data, registered with it
//   stat_count out  per-leaf accepted-message counters, STAT_W bits each
//
// Configuration macro:
//   LEAF_UPLINK_STATS_EN - when defined, every leaf gets a saturating
//   counter of accepted handshakes. When undefined, stat_count is tied to 0
//   and no counter flops exist. Arbitration is identical in both builds.
// -----------------------------------------------------------------------------
module leaf_uplink_rr_arbiter #(
    parameter int NUM_LEAVES = 4,
    parameter int DATA_WIDTH = 64,
    parameter int STAT_W     = 32,
    localparam int SRC_W     = (NUM_LEAVES > 1) ? $clog2(NUM_LEAVES) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [DATA_WIDTH*NUM_LEAVES-1:0] in_data,
    input  logic [NUM_LEAVES-1:0]          in_valid,
    output logic [NUM_LEAVES-1:0]          in_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [SRC_W-1:0]               out_src,
    output logic [STAT_W*NUM_LEAVES-1:0]   stat_count
);

    logic [SRC_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0]      src_q, src_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;

    logic                  load;
    logic                  any_valid;
    logic [SRC_W-1:0]      winner;
    logic [DATA_WIDTH-1:0] leaf_data [NUM_LEAVES];

    // The output register can take a new word when it is empty or being drained.
    assign load      = !valid_q || out_ready;
    assign any_valid = |in_valid;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LEAVES; gi++) begin : gen_leaf
            assign leaf_data[gi] = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
            // Only the winner sees ready; reset suppresses all grants.
            assign in_ready[gi]  = !reset && load && any_valid
                                   && (winner == SRC_W'(gi));
        end
    endgenerate

    // Round-robin search: scan from the farthest offset down to offset 0 so the
    // valid leaf closest to rr_ptr_q (in wrap-around order) is the last written.
    always_comb begin
        int idx;
        winner = '0;
        idx    = 0;
        for (int k = NUM_LEAVES - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_LEAVES) begin
                idx = idx - NUM_LEAVES;
            end
            if (in_valid[idx]) begin
                winner = SRC_W'(idx);
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        src_d    = src_q;
        data_d   = data_q;
        valid_d  = valid_q;
        if (load) begin
            if (any_valid) begin
                data_d   = leaf_data[winner];
                src_d    = winner;
                valid_d  = 1'b1;
                rr_ptr_d = (winner == SRC_W'(NUM_LEAVES - 1)) ? '0 : winner + 1'b1;
            end else begin
                // Empty cycle: drop valid but keep the last word and pointer.
                valid_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= '0;
            src_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            src_q    <= src_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_src   = src_q;
    assign out_valid = valid_q;

`ifdef LEAF_UPLINK_STATS_EN
    generate
        for (gi = 0; gi < NUM_LEAVES; gi++) begin : gen_stat
            logic [STAT_W-1:0] cnt_q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q <= '0;
                end else if (in_valid[gi] && in_ready[gi] && !(&cnt_q)) begin
                    // Saturate at all-ones rather than wrapping.
                    cnt_q <= cnt_q + 1'b1;
                end
            end
            assign stat_count[gi*STAT_W +: STAT_W] = cnt_q;
        end
    endgenerate
`else
    assign stat_count = '0;
`endif

endmodule

// File: tb/tb_leaf_uplink_rr_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for leaf_uplink_rr_arbiter (4 leaves, 64-bit data, 4-bit counters).
// A reference model tracks the round-robin pointer and output valid; every
// predicted grant pushes {data, src} onto a scoreboard queue that is popped
// when the output word is accepted.
// -----------------------------------------------------------------------------
module tb_leaf_uplink_rr_arbiter;

    localparam int N   = 4;
    localparam int DW  = 64;
    localparam int SW  = 2;
    localparam int STW = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [DW*N-1:0]   in_data;
    logic [N-1:0]      in_valid;
    logic [N-1:0]      in_ready;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready;
    logic [SW-1:0]     out_src;
    logic [STW*N-1:0]  stat_count;

    always #5 clk = ~clk;

    leaf_uplink_rr_arbiter #(
        .NUM_LEAVES (N),
        .DATA_WIDTH (DW),
        .STAT_W     (STW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_src    (out_src),
        .stat_count (stat_count)
    );

    int              n_checks = 0;
    int              n_fail   = 0;
    logic            m_valid;
    logic [SW-1:0]   m_rr;
    int              m_stat [N];
    logic [DW+SW-1:0] sb [$];
    logic [55:0]     seq = 56'h1;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int model_winner();
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (int'(m_rr) + k) % N;
            if (in_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic set_leaf(input int i, input logic [DW-1:0] d);
        in_data[i*DW +: DW] = d;
    endtask

    task automatic fill_data();
        for (int i = 0; i < N; i++) begin
            set_leaf(i, {8'(i), seq});
            seq++;
        end
    endtask

    // Called just after a negedge with inputs applied; checks, advances one
    // clock, updates the model and returns at the next negedge.
    task automatic step();
        int              w;
        logic            load;
        logic [N-1:0]    exp_rdy;
        logic [STW*N-1:0] exp_stat;
        #1;
        load    = !m_valid || out_ready;
        w       = model_winner();
        exp_rdy = '0;
        if (!reset && load && (w >= 0)) exp_rdy[w] = 1'b1;
        check_eq("in_ready", 128'(in_ready), 128'(exp_rdy));
        check_eq("out_valid", 128'(out_valid), 128'(m_valid));
        if (m_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard: got out_valid=1 expected an entry in queue");
            end else begin
                check_eq("out_data", 128'(out_data), 128'(sb[0][DW+SW-1:SW]));
                check_eq("out_src", 128'(out_src), 128'(sb[0][SW-1:0]));
            end
        end
        exp_stat = '0;
`ifdef LEAF_UPLINK_STATS_EN
        for (int i = 0; i < N; i++) exp_stat[i*STW +: STW] = STW'(m_stat[i]);
`endif
        check_eq("stat_count", 128'(stat_count), 128'(exp_stat));
        @(posedge clk);
        if (reset) begin
            m_valid = 1'b0;
            m_rr    = '0;
            sb.delete();
            for (int i = 0; i < N; i++) m_stat[i] = 0;
        end else begin
            if (m_valid && out_ready) begin
                $display("out word src=%0d data=%h", sb[0][SW-1:0], sb[0][DW+SW-1:SW]);
                void'(sb.pop_front());
            end
            if (load) begin
                if (w >= 0) begin
                    sb.push_back({in_data[w*DW +: DW], SW'(w)});
                    m_valid = 1'b1;
                    m_rr    = (w == N - 1) ? '0 : SW'(w + 1);
                    if (m_stat[w] < (1 << STW) - 1) m_stat[w]++;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b1;
        m_valid   = 1'b0;
        m_rr      = '0;
        for (int i = 0; i < N; i++) m_stat[i] = 0;

        @(posedge clk);
        @(negedge clk);
        step();
        step();
        reset = 1'b0;
        #1;
        check_eq("rst_out_data", 128'(out_data), 128'(0));
        check_eq("rst_out_src", 128'(out_src), 128'(0));
        check_eq("rst_out_valid", 128'(out_valid), 128'(0));

        // Single leaf 2; pointer then sits at 3.
        set_leaf(2, 64'hA5A5_0000_0000_0001);
        in_valid = 4'b0100;
        step();
        in_valid = 4'b0000;
        step();
        step();

        // Wrap: only leaves 0 and 3, pointer at 3 -> grants 3, 0, 3.
        in_valid = 4'b1001;
        for (int c = 0; c < 3; c++) begin
            fill_data();
            step();
        end
        in_valid = 4'b0000;
        step();

        // All leaves valid, full throughput: grants 0,1,2,3,0,1,2,3.
        in_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            fill_data();
            step();
        end

        // Backpressure for 5 cycles, then release.
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) step();
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            fill_data();
            step();
        end

        // Reset while a word is held and leaves are valid.
        out_ready = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            fill_data();
            step();
        end

        // Random traffic and backpressure.
        for (int c = 0; c < 60; c++) begin
            in_valid  = N'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            fill_data();
            step();
        end

        // 20 words from leaf 1; its counter saturates in the stats build.
        out_ready = 1'b1;
        in_valid  = 4'b0010;
        for (int c = 0; c < 20; c++) begin
            fill_data();
            step();
        end

        in_valid = '0;
        for (int c = 0; c < 3; c++) step();
        check_eq("sb_drained", 128'(sb.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
